pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32I pipeline. It drives the stall input of the PC register and the IF/ID register, and drives the flush (bubble) inputs of IF/ID and ID/EX. It arbitrates among branch redirect, multi-cycle (mul/div) unit occupancy, load-use hazards and instruction-memory wait states. It also sequences the multi-cycle unit's start/done/abort handshake and keeps a stall-cycle performance counter.

Parameters:
XLEN, 32, PC/redirect target width
RA_W, 5, register-address width
CNT_W, 16, stall performance counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
id_rs1  in  RA_W  source reg 1 of the instruction in ID
id_rs2  in  RA_W  source reg 2 of the instruction in ID
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
id_mc_op  in  1  ID instruction needs the multi-cycle unit
ex_rd  in  RA_W  destination reg of the instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_branch_taken  in  1  EX resolved a taken branch or jump
ex_branch_target  in  XLEN  redirect target from EX
imem_ready  in  1  instruction memory returns a valid fetch this cycle
mc_done  in  1  multi-cycle unit result valid (1-cycle pulse)
mc_start  out  1  launch the multi-cycle unit (1-cycle pulse)
mc_abort  out  1  cancel the in-flight multi-cycle operation
stall_pc  out  1  hold the PC register
stall_ifid  out  1  hold the IF/ID register
flush_ifid  out  1  load a NOP into IF/ID
flush_idex  out  1  load a NOP into ID/EX
pc_sel  out  1  1 selects pc_redirect as the next PC
pc_redirect  out  XLEN  next-PC value when pc_sel=1
stall_cnt  out  CNT_W  cycles with stall_pc=1, saturating

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset: state=RUN, stall_cnt=0. All control outputs are 0 while rst=1. pc_redirect=0. Reset mid-MC_BUSY returns to RUN with no mc_abort pulse, because the unit is reset by the same rst.
- Registered FSM. States:
  - RUN: normal flow.
  - MC_BUSY: waiting for the multi-cycle unit.
  - MC_DONE: single cycle; the ID instruction advances.
- Control outputs are combinational from state and inputs, so there is zero-cycle latency. The state update happens on the clk edge.
- load_use = ex_mem_read & (ex_rd!=0) & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- Priority, highest first: branch > MC > load_use > imem wait.
- Branch (ex_branch_taken=1, any state):
  - Outputs: pc_sel=1, pc_redirect=ex_branch_target, flush_ifid=1, flush_idex=1, stall_pc=0, stall_ifid=0, mc_start=0.
  - If state=MC_BUSY: mc_abort=1 for that cycle and next state=RUN.
  - If state=MC_DONE: next state=RUN.
  - A branch coinciding with mc_done also aborts; the result is discarded.
- RUN with id_mc_op=1 and no load_use:
  - Outputs: mc_start=1, stall_pc=1, stall_ifid=1, flush_idex=1.
  - Next state=MC_BUSY.
- MC_BUSY with mc_done=0: stall_pc=1, stall_ifid=1, flush_idex=1.
- MC_BUSY with mc_done=1: same outputs, next state=MC_DONE.
- MC_DONE:
  - No MC stall; the load_use and imem rules apply normally.
  - mc_start is suppressed even though id_mc_op is still 1.
  - Next state=RUN.
- load_use (RUN or MC_DONE, no branch): stall_pc=1, stall_ifid=1, flush_idex=1 for exactly the cycles load_use holds. An MC op blocked by load_use starts on the first cycle load_use=0.
- imem_ready=0 (no higher event): stall_pc=1, flush_ifid=1, stall_ifid=0.
- imem_ready=0 coinciding with a stall_ifid source: stall_ifid=1 and flush_ifid=0, so the held instruction is never destroyed.
- pc_redirect = ex_branch_target when pc_sel=1, else 0.
- stall_cnt: +1 on each clk edge where stall_pc=1. It saturates at all-ones (no wrap) and is cleared only by rst.
- mc_start is never asserted twice without an intervening mc_done or mc_abort.

Decomposition:
- Shared package pipe_ctrl_pkg: FSM state encoding (RUN=2'd0, MC_BUSY=2'd1, MC_DONE=2'd2), the RA_W and XLEN defaults, and the x0 register constant.
- One natural sub-module: sat_counter (parameterised width, enable, async active-high clear), reused for stall_cnt.

Test Plan:
1. Reset: assert rst mid-cycle → all outputs 0 asynchronously, stall_cnt=0, state=RUN.
2. Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_used=1 for 1 cycle → stall_pc=stall_ifid=flush_idex=1 for that cycle only; stall_cnt increments by 1. Repeat with ex_rd=0 → no stall.
3. MC op: id_mc_op=1 with mc_done pulsed 4 cycles after mc_start → mc_start for 1 cycle; stalls for 5 cycles; MC_DONE cycle has no stall and no second mc_start; stall_cnt=5.
4. Branch abort: branch taken with target 0x0000_0100 while in MC_BUSY → same cycle mc_abort=1, pc_sel=1, pc_redirect=0x100, both flushes, stalls=0; next state RUN.
5. imem wait plus load-use: imem_ready=0 together with load_use → stall_ifid=1, flush_ifid=0, flush_idex=1. imem_ready=0 alone → flush_ifid=1, stall_ifid=0.
6. Saturation: CNT_W=4, hold a stall for 20 cycles → stall_cnt stops at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline hazard controller.
// Holds the sequencer state encoding, the default XLEN/RA_W widths and the
// x0 register index (writes to x0 never create a load-use dependency).
package pipe_ctrl_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RA_W_DEF = 5;
    localparam int X0_REG   = 0;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: bundle of every hazard-controller signal except clk/rst.
//   slave  modport : the controller (reads ID/EX/imem/mc status, drives controls)
//   master modport : the pipeline side (drives status, reads controls)
//   dbg_state      : current sequencer state, for observation only
//
// Multi-cycle unit handshake: mc_start is a one-cycle launch pulse; the unit
// answers with a one-cycle mc_done pulse when its result is valid. mc_abort is
// a one-cycle pulse that cancels the in-flight operation (a result arriving in
// the same cycle is discarded). A new mc_start only follows mc_done or
// mc_abort of the previous operation.
interface pipe_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int RA_W  = RA_W_DEF,
    parameter int CNT_W = 16
) ();

    logic [RA_W-1:0]  id_rs1;
    logic [RA_W-1:0]  id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic             id_mc_op;
    logic [RA_W-1:0]  ex_rd;
    logic             ex_mem_read;
    logic             ex_branch_taken;
    logic [XLEN-1:0]  ex_branch_target;
    logic             imem_ready;
    logic             mc_done;

    logic             mc_start;
    logic             mc_abort;
    logic             stall_pc;
    logic             stall_ifid;
    logic             flush_ifid;
    logic             flush_idex;
    logic             pc_sel;
    logic [XLEN-1:0]  pc_redirect;
    logic [CNT_W-1:0] stall_cnt;
    state_t           dbg_state;

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_mc_op,
        input  ex_rd, ex_mem_read, ex_branch_taken, ex_branch_target,
        input  imem_ready, mc_done,
        output mc_start, mc_abort, stall_pc, stall_ifid, flush_ifid,
        output flush_idex, pc_sel, pc_redirect, stall_cnt, dbg_state
    );

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_mc_op,
        output ex_rd, ex_mem_read, ex_branch_taken, ex_branch_target,
        output imem_ready, mc_done,
        input  mc_start, mc_abort, stall_pc, stall_ifid, flush_ifid,
        input  flush_idex, pc_sel, pc_redirect, stall_cnt, dbg_state
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// sat_counter: up-counter that stops at all-ones instead of wrapping.
//   clk   : rising-edge clock
//   clr   : asynchronous active-high clear
//   en    : count this cycle
//   count : current value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage RV32I pipeline.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : pipe_hazard_ctrl_if slave port (ID/EX hazard info, imem ready,
//              multi-cycle handshake, stall/flush/redirect controls,
//              saturating stall-cycle counter, debug state)
// Priority: branch redirect > multi-cycle occupancy > load-use > imem wait.
// All controls are combinational from state and inputs; forced to 0 in reset.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int RA_W  = RA_W_DEF,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    state_t           state;
    state_t           state_nxt;
    logic             load_use;
    logic             mc_start;
    logic             mc_abort;
    logic             stall_pc;
    logic             stall_ifid;
    logic             flush_ifid;
    logic             flush_idex;
    logic             pc_sel;
    logic [XLEN-1:0]  pc_redirect;
    logic [CNT_W-1:0] stall_cnt;

    assign load_use = bus.ex_mem_read
                   && (bus.ex_rd != RA_W'(X0_REG))
                   && ((bus.id_rs1_used && (bus.id_rs1 == bus.ex_rd))
                    || (bus.id_rs2_used && (bus.id_rs2 == bus.ex_rd)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        mc_start    = 1'b0;
        mc_abort    = 1'b0;
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        pc_sel      = 1'b0;
        pc_redirect = '0;
        if (!rst) begin
            if (bus.ex_branch_taken) begin
                // Redirect wins over everything; an in-flight MC op is
                // cancelled even if its done pulse arrives this cycle.
                pc_sel      = 1'b1;
                pc_redirect = bus.ex_branch_target;
                flush_ifid  = 1'b1;
                flush_idex  = 1'b1;
                mc_abort    = (state == MC_BUSY);
                state_nxt   = RUN;
            end else begin
                case (state)
                    MC_BUSY: begin
                        stall_pc   = 1'b1;
                        stall_ifid = 1'b1;
                        flush_idex = 1'b1;
                        if (bus.mc_done) begin
                            state_nxt = MC_DONE;
                        end
                    end
                    default: begin
                        // RUN or MC_DONE. In MC_DONE the ID instruction is the
                        // one that just finished, so it must not relaunch.
                        if (load_use) begin
                            stall_pc   = 1'b1;
                            stall_ifid = 1'b1;
                            flush_idex = 1'b1;
                        end else if ((state == RUN) && bus.id_mc_op) begin
                            mc_start   = 1'b1;
                            stall_pc   = 1'b1;
                            stall_ifid = 1'b1;
                            flush_idex = 1'b1;
                            state_nxt  = MC_BUSY;
                        end
                        if (state == MC_DONE) begin
                            state_nxt = RUN;
                        end
                    end
                endcase
                // Fetch wait: hold the PC. If IF/ID is already held, keep its
                // instruction instead of bubbling it.
                if (!bus.imem_ready) begin
                    stall_pc   = 1'b1;
                    flush_ifid = !stall_ifid;
                end
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .en    (stall_pc),
        .count (stall_cnt)
    );

    assign bus.mc_start    = mc_start;
    assign bus.mc_abort    = mc_abort;
    assign bus.stall_pc    = stall_pc;
    assign bus.stall_ifid  = stall_ifid;
    assign bus.flush_ifid  = flush_ifid;
    assign bus.flush_idex  = flush_idex;
    assign bus.pc_sel      = pc_sel;
    assign bus.pc_redirect = pc_redirect;
    assign bus.stall_cnt   = stall_cnt;
    assign bus.dbg_state   = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: stimulus issues one cycle of inputs at each falling
// edge and pushes the reference model's expected outputs; a monitor pops and
// compares a few ns later, well before the next rising edge. A second DUT with
// a 4-bit counter shares the inputs to exercise counter saturation.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int XLEN = 32;
    localparam int RA_W = 5;
    localparam int EW   = 7 + XLEN + 16 + 4 + 2;

    typedef struct {
        logic [RA_W-1:0] rs1, rs2, rd;
        logic            u1, u2, mc_op, mem_read, br, imem_ready, mc_done;
        logic [XLEN-1:0] target;
    } stim_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(16)) bus ();
    pipe_hazard_ctrl_if #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(4))  bus4 ();

    assign bus4.id_rs1           = bus.id_rs1;
    assign bus4.id_rs2           = bus.id_rs2;
    assign bus4.id_rs1_used      = bus.id_rs1_used;
    assign bus4.id_rs2_used      = bus.id_rs2_used;
    assign bus4.id_mc_op         = bus.id_mc_op;
    assign bus4.ex_rd            = bus.ex_rd;
    assign bus4.ex_mem_read      = bus.ex_mem_read;
    assign bus4.ex_branch_taken  = bus.ex_branch_taken;
    assign bus4.ex_branch_target = bus.ex_branch_target;
    assign bus4.imem_ready       = bus.imem_ready;
    assign bus4.mc_done          = bus.mc_done;

    pipe_hazard_ctrl #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(16)) dut (
        .clk (clk), .rst (rst), .bus (bus.slave)
    );
    pipe_hazard_ctrl #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(4)) dut4 (
        .clk (clk), .rst (rst), .bus (bus4.slave)
    );

    logic [EW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    stim_t         s;
    logic          rst_req  = 1'b0;

    // Reference model: MC unit occupancy, "just finished" flag, stall tallies.
    bit            m_busy = 1'b0;
    bit            m_done = 1'b0;
    int unsigned   m_cnt  = 0;
    int unsigned   m_cnt4 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t t;
        t.rs1 = '0; t.rs2 = '0; t.rd = '0;
        t.u1 = 0; t.u2 = 0; t.mc_op = 0; t.mem_read = 0; t.br = 0;
        t.imem_ready = 1; t.mc_done = 0; t.target = '0;
        return t;
    endfunction

    // One cycle: drive inputs, predict outputs, advance the model.
    task automatic step();
        logic lu, st, ab, spc, sif, fif, fid, ps;
        logic [XLEN-1:0] red;
        logic [1:0] exp_state;
        @(negedge clk);
        rst                  = rst_req;
        bus.id_rs1           = s.rs1;
        bus.id_rs2           = s.rs2;
        bus.id_rs1_used      = s.u1;
        bus.id_rs2_used      = s.u2;
        bus.id_mc_op         = s.mc_op;
        bus.ex_rd            = s.rd;
        bus.ex_mem_read      = s.mem_read;
        bus.ex_branch_taken  = s.br;
        bus.ex_branch_target = s.target;
        bus.imem_ready       = s.imem_ready;
        bus.mc_done          = s.mc_done;

        {st, ab, spc, sif, fif, fid, ps} = '0;
        red = '0;
        if (rst_req) begin
            m_busy = 0; m_done = 0; m_cnt = 0; m_cnt4 = 0;
            exp_q.push_back({7'b0, red, 16'd0, 4'd0, 2'd0});
        end else begin
            exp_state = m_busy ? 2'd1 : (m_done ? 2'd2 : 2'd0);
            lu = s.mem_read && (s.rd != 0) &&
                 ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
            if (s.br) begin
                ps = 1; red = s.target; fif = 1; fid = 1; ab = m_busy;
                m_busy = 0; m_done = 0;
            end else begin
                if (m_busy) begin
                    spc = 1; sif = 1; fid = 1;
                    if (s.mc_done) begin m_busy = 0; m_done = 1; end
                end else begin
                    if (lu) begin
                        spc = 1; sif = 1; fid = 1;
                    end else if (!m_done && s.mc_op) begin
                        st = 1; spc = 1; sif = 1; fid = 1; m_busy = 1;
                    end
                    m_done = 0;
                end
                if (!s.imem_ready) begin
                    spc = 1;
                    fif = !sif;
                end
            end
            exp_q.push_back({st, ab, spc, sif, fif, fid, ps, red,
                             m_cnt[15:0], m_cnt4[3:0], exp_state});
            if (spc) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
        end
    endtask

    task automatic do_reset();
        s = idle();
        s.br = 1; s.mc_op = 1; s.imem_ready = 0; s.target = 32'hdead_beef;
        rst_req = 1;
        step();
        rst_req = 0;
        s = idle();
    endtask

    // Monitor: compares each presented cycle against the oldest expectation.
    initial begin
        logic [EW-1:0] e, a;
        string nm[7];
        nm = '{"mc_start", "mc_abort", "stall_pc", "stall_ifid", "flush_ifid", "flush_idex", "pc_sel"};
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.mc_start, bus.mc_abort, bus.stall_pc, bus.stall_ifid,
                     bus.flush_ifid, bus.flush_idex, bus.pc_sel, bus.pc_redirect,
                     bus.stall_cnt, bus4.stall_cnt, 2'(bus.dbg_state)};
                for (int i = 0; i < 7; i++) begin
                    check(nm[i], 64'(a[EW-1-i]), 64'(e[EW-1-i]));
                end
                check("pc_redirect", 64'(a[53:22]), 64'(e[53:22]));
                check("stall_cnt",   64'(a[21:6]),  64'(e[21:6]));
                check("stall_cnt4",  64'(a[5:2]),   64'(e[5:2]));
                check("state",       64'(a[1:0]),   64'(e[1:0]));
                check("mc_abort_4b", 64'(bus4.mc_abort), 64'(e[EW-2]));
            end
        end
    end

    initial begin
        s = idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Reset asserted mid-cycle with active inputs: outputs forced low.
        do_reset();

        // Load-use on rs1, then the same with ex_rd = x0.
        s.mem_read = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1;
        step();
        s = idle(); step();
        s.mem_read = 1; s.rd = 0; s.rs1 = 0; s.u1 = 1;
        step();
        s = idle(); step();

        // MC op: done four cycles after start, op still in ID at MC_DONE.
        s.mc_op = 1;
        step();
        repeat (3) step();
        s.mc_done = 1; step();
        s.mc_done = 0; step();
        s = idle(); step();

        // Branch to 0x100 while the MC unit is busy.
        s.mc_op = 1; step();
        s.mc_op = 1; step();
        s.br = 1; s.target = 32'h0000_0100; step();
        s = idle(); step();

        // Fetch wait with load-use, then fetch wait alone.
        s.imem_ready = 0; s.mem_read = 1; s.rd = 7; s.rs2 = 7; s.u2 = 1;
        step();
        s = idle(); s.imem_ready = 0; step();
        s = idle(); step();

        // Held stall for 20 cycles from reset: 4-bit counter stops at 15.
        do_reset();
        s.mem_read = 1; s.rd = 3; s.rs1 = 3; s.u1 = 1;
        repeat (20) step();
        s = idle(); repeat (2) step();

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            s.rs1        = RA_W'($urandom_range(0, 3));
            s.rs2        = RA_W'($urandom_range(0, 3));
            s.rd         = RA_W'($urandom_range(0, 3));
            s.u1         = 1'($urandom_range(0, 1));
            s.u2         = 1'($urandom_range(0, 1));
            s.mc_op      = ($urandom_range(0, 3) == 0);
            s.mem_read   = ($urandom_range(0, 2) == 0);
            s.br         = ($urandom_range(0, 11) == 0);
            s.target     = $urandom;
            s.imem_ready = ($urandom_range(0, 4) != 0);
            s.mc_done    = m_busy && ($urandom_range(0, 2) == 0);
            rst_req      = ($urandom_range(0, 199) == 0);
            step();
            rst_req      = 0;
        end
        s = idle(); step();

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        repeat (1) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
